ms_cmd_que: RTL

Instruction queue feeding the command decoder. Fetches aligned 32-bit code words from the code-memory port and holds up to 8 halfwords. Presents a 48-bit window starting at the current IP (AQueTop, AIpThis). Retires 1–3 halfwords per accepted command, as reported by the decoder's ACmdLen. Sits directly between the code fetch bus and the decoder; serves both CPU types, since both decoders read the same window.

---
 rtl/ms_cmd_que.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ms_cmd_que.sv
// ms_cmd_que: instruction queue between the code fetch bus and the command
// decoder. Holds up to 8 halfwords fetched as aligned 32-bit words and shows a
// three-halfword window at the current IP. Retires 1..3 halfwords per command.
// Optional build macro MS_CMD_QUE_STAT_EN adds the AStallCnt stall counter.
module ms_cmd_que (
    input  logic        AClkH,
    input  logic        AResetHN,
    input  logic        AClkHEn,
    input  logic        AFlush,
    input  logic [23:1] AFlushIp,
    output logic        AFetchReq,
    output logic [23:2] AFetchAddr,
    input  logic        AFetchAck,
    input  logic [31:0] AFetchData,
    output logic [47:0] AQueTop,
    output logic [23:1] AIpThis,
    input  logic [1:0]  ACmdLen,
    output logic        ACmdLenValid,
    input  logic        ACmdAccept,
`ifdef MS_CMD_QUE_STAT_EN
    output logic [15:0] AStallCnt,
`endif
    output logic [3:0]  AQueFill
);

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} fetchState_t;

    fetchState_t fetchState;
    logic [15:0] queBuf [8];
    logic [2:0]  rdPtr;
    logic [3:0]  fillCnt;
    logic [23:1] ipReg;
    logic [23:2] fAddr;
    logic [23:2] reqAddr;
    logic        dropFlag;
    logic        skipFlag;
    logic        haltFlag;

    logic        ackTaken;
    logic        pushing;
    logic [3:0]  popLen;
    logic [3:0]  pushCnt;
    logic [3:0]  fillNext;
    logic [23:2] fAddrNext;
    logic [2:0]  wrLoIdx;
    logic [2:0]  wrHiIdx;
    logic [15:0] wrLoData;

    // Only an ack to an outstanding request counts; a late ack while idle is ignored
    assign ackTaken  = (fetchState == REQ) && AFetchAck;
    assign pushing   = ackTaken && !dropFlag;
    assign pushCnt   = pushing ? (skipFlag ? 4'd1 : 4'd2) : 4'd0;
    assign popLen    = (ACmdAccept && ACmdLenValid) ? {2'b00, ACmdLen} : 4'd0;
    assign fillNext  = fillCnt - popLen + pushCnt;
    assign fAddrNext = fAddr + {21'd0, pushing};

    // New halfwords land right behind the current tail; a skipped word only
    // contributes its upper halfword
    assign wrLoIdx  = rdPtr + fillCnt[2:0];
    assign wrHiIdx  = wrLoIdx + 3'd1;
    assign wrLoData = skipFlag ? AFetchData[31:16] : AFetchData[15:0];

    assign ACmdLenValid = (fillCnt != 4'd0) && (fillCnt >= {2'b00, ACmdLen}) && (ACmdLen != 2'd0);
    assign AQueFill     = fillCnt;
    assign AIpThis      = ipReg;
    assign AFetchReq    = (fetchState == REQ);
    assign AFetchAddr   = reqAddr;

    // Window: three consecutive entries from the read pointer, empty slots read 0
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gWin
            logic [2:0] winIdx;
            assign winIdx = rdPtr + 3'(gi);
            assign AQueTop[16*gi +: 16] = (4'(gi) < fillCnt) ? queBuf[winIdx] : 16'h0000;
        end
    endgenerate

    // Halfword storage; data is never reset because the fill count masks it
    always_ff @(posedge AClkH) begin
        if (AClkHEn && !AFlush && pushing) begin
            for (int i = 0; i < 8; i++) begin
                if (wrLoIdx == 3'(i)) begin
                    queBuf[i] <= wrLoData;
                end else if (!skipFlag && wrHiIdx == 3'(i)) begin
                    queBuf[i] <= AFetchData[31:16];
                end
            end
        end
    end

    // Queue pointers, IP tracking and the fetch request FSM
    always_ff @(posedge AClkH or negedge AResetHN) begin
        if (!AResetHN) begin
            fetchState <= IDLE;
            rdPtr      <= 3'd0;
            fillCnt    <= 4'd0;
            ipReg      <= '0;
            fAddr      <= '0;
            reqAddr    <= '0;
            dropFlag   <= 1'b0;
            skipFlag   <= 1'b0;
            haltFlag   <= 1'b1;
        end else if (AClkHEn) begin
            if (AFlush) begin
                rdPtr    <= 3'd0;
                fillCnt  <= 4'd0;
                ipReg    <= AFlushIp;
                fAddr    <= AFlushIp[23:2];
                skipFlag <= AFlushIp[1];
                haltFlag <= 1'b0;
                if (fetchState == REQ && !AFetchAck) begin
                    // Old request still on the bus: keep it up, throw its data away
                    dropFlag <= 1'b1;
                end else begin
                    dropFlag   <= 1'b0;
                    fetchState <= REQ;
                    reqAddr    <= AFlushIp[23:2];
                end
            end else begin
                rdPtr   <= rdPtr + popLen[2:0];
                fillCnt <= fillNext;
                ipReg   <= ipReg + 23'(popLen);
                fAddr   <= fAddrNext;
                if (ackTaken) begin
                    if (dropFlag) begin
                        dropFlag <= 1'b0;
                    end else begin
                        skipFlag <= 1'b0;
                    end
                end
                // Request only if two more halfwords fit after this cycle's changes
                if (fetchState == IDLE || ackTaken) begin
                    if (!haltFlag && fillNext <= 4'd6) begin
                        fetchState <= REQ;
                        reqAddr    <= fAddrNext;
                    end else begin
                        fetchState <= IDLE;
                    end
                end
            end
        end
    end

`ifdef MS_CMD_QUE_STAT_EN
    // Saturating count of enabled, running cycles where the decoder is starved
    always_ff @(posedge AClkH or negedge AResetHN) begin
        if (!AResetHN) begin
            AStallCnt <= 16'd0;
        end else if (AClkHEn) begin
            if (AFlush) begin
                AStallCnt <= 16'd0;
            end else if (!haltFlag && !ACmdLenValid && AStallCnt != 16'hFFFF) begin
                AStallCnt <= AStallCnt + 16'd1;
            end
        end
    end
`endif

endmodule
